imem_loader: RTL and testbench
==============================

# imem_loader

Load controller and port arbiter for the 512×128-bit instruction memory with a write port. It accepts a stream of 32-bit instruction words from an external source, such as a UART receiver, and packs four words into one 128-bit line. It writes each line to consecutive memory addresses starting at 0. When no load is active, it passes the core fetch address to the memory's single address port. During a load it owns the port and stalls fetch.

## Interface
Parameters:
- `WORD_W`, default 32: instruction word width, equal to `INSN_LEN`.
- `ADDR_W`, default 9: memory line address width (512 lines).

Ports:
- `clk` in 1: the block's only clock; all state updates on the rising edge.
- `reset_x` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse that begins a load. Sampled only in IDLE.
- `load_len` in `ADDR_W`: number of lines to load, minus one (0 = 1 line, 511 = 512 lines). Sampled with `start`.
- `abort` in 1: cancels an active load.
- `in_valid` in 1: input word valid.
- `in_data` in `WORD_W`: input word.
- `in_ready` out 1: block accepts a word on this cycle.
- `fetch_addr` in `ADDR_W`: core fetch line address.
- `fetch_stall` out 1: the core must not rely on memory read data.
- `mem_addr` out `ADDR_W`: memory address port.
- `mem_we` out 1: memory write enable.
- `mem_wdata` out `4*WORD_W`: memory write data.
- `busy` out 1: a load is in progress.
- `done` out 1: single-cycle pulse when the final line has been written.
- `cksum` out 32: running checksum (see Configuration).

## Operation
States:
- IDLE: `in_ready`=0, `busy`=0, `mem_we`=0, `mem_addr`=`fetch_addr`. On `start`, latch `load_len`, clear `line_cnt` and `word_cnt`, go to FILL.
- FILL: `in_ready`=1. When `in_valid` is high, `in_data` is stored in the pack register:
  - word k of a line (k = `word_cnt` 0..3) goes to bits [32k+31:32k], so the first word received lands in bits [31:0];
  - `word_cnt` increments;
  - after the 4th word, go to WRITE.
- WRITE: `in_ready`=0, `mem_we`=1, `mem_addr`=`line_cnt`, `mem_wdata`=pack register.
  - If `line_cnt`==latched `load_len`, go to DONE.
  - Otherwise increment `line_cnt`, clear `word_cnt`, and return to FILL.
- DONE: `done`=1 for this one cycle, `mem_we`=0, then go to IDLE.

Signal definitions:
- `busy` = (state != IDLE).
- `fetch_stall` = `busy`.
- In FILL and DONE, `mem_addr` = `line_cnt`.
- `mem_addr` is a combinational mux. `mem_we` and `in_ready` decode directly from the current state.

Arithmetic and widths:
- `word_cnt` is 2 bits. `line_cnt` is `ADDR_W` bits and never wraps: the compare against `load_len` terminates the load first.

Boundary conditions:
- `start` outside IDLE: ignored. `load_len` is not re-latched.
- `abort` in any non-IDLE state: next state is IDLE. No write of a partial line, no `done` pulse. Lines already written stay in memory.
- `abort` and a word accepted in the same cycle: `abort` wins and the word is dropped. `in_ready` still reads 1 in that cycle.
- `abort` in WRITE: that cycle's write still occurs, because `mem_we` is a state decode.
- `abort` in IDLE: no effect.
- `in_valid` low in FILL: hold state with no timeout.
- Reset asserted mid-load: immediately returns to IDLE, clears all counters and the pack register, and drops the partial line.

## Timing
Reset values:
- `in_ready`=0, `busy`=0, `fetch_stall`=0, `done`=0, `mem_we`=0.
- `mem_wdata`=0 (pack register cleared), `cksum`=0.
- `mem_addr`=`fetch_addr`.

Latencies and rates:
- `start` to first `in_ready`: 1 cycle.
- 4th accepted word to `mem_we`: the next cycle.
- Throughput: 1 line per 5 cycles with continuous `in_valid`.
- Last write to `done`: 1 cycle. `done` to `busy`=0: 1 cycle.
- `load_len`=N: N+1 writes, and `done` arrives 5(N+1)+1 cycles after the `start` cycle with continuous input.

Read path:
- Memory read data is registered in the memory itself. The core may use read data starting 2 cycles after `fetch_stall` falls.

## Configuration
- `IMEM_LOADER_CKSUM_EN` defined:
  - `cksum` = mod-2^32 sum of every word accepted since the last `start`;
  - cleared on `start` and on reset;
  - holds its value after `done` or `abort`.
- `IMEM_LOADER_CKSUM_EN` undefined: `cksum` is tied to 0 and no adder is built.

## Test plan
- Reset, then `start` with `load_len`=0 and words 0x11,0x22,0x33,0x44 sent back-to-back. Expect:
  - one write at address 0 with `mem_wdata`=0x00000044_00000033_00000022_00000011;
  - `done` pulsed 1 cycle after the write;
  - `cksum`=0xAA when the macro is defined, otherwise 0.
- `load_len`=2 with 12 words and random `in_valid` gaps → writes at addresses 0, 1, 2 in order. `fetch_stall`=1 throughout; `mem_addr` returns to `fetch_addr`=0x1F5 after DONE.
- `abort` after 6 words of a `load_len`=3 load → one write at address 0 only, no `done`, IDLE on the next cycle, `cksum` holds the sum of the 6 words.
- `start` pulsed during FILL with a different `load_len` → ignored; the original line count completes.
- `reset_x` asserted during WRITE of line 5, then released → all outputs at reset values. A new `start` writes from address 0 again.
- `load_len`=511 with continuous input → 512 writes, the last at address 511, and `done` arrives 2561 cycles after `start`.

Source files
------------

// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader
// Load controller and address-port arbiter for the 512 x 128-bit instruction
// memory. Incoming 32-bit words are packed four to a line, and each line is
// written to consecutive line addresses starting at 0. While no load is active
// the core fetch address owns the memory address port. During a load the
// loader owns the port and fetch is stalled.
//
// Optional feature: define IMEM_LOADER_CKSUM_EN to build a running mod-2^32
// checksum of every accepted word. Without it, cksum is tied to zero and no
// adder is built.
//
// Input handshake: a word transfers on a rising edge where in_valid and
// in_ready are both high and abort is low. in_ready depends only on the FSM
// state, never on in_valid. An abort in the same cycle drops the word even
// though in_ready reads 1.
module imem_loader #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic                clk,
   input  logic                reset_x,
   input  logic                start,
   input  logic [ADDR_W-1:0]   load_len,
   input  logic                abort,
   input  logic                in_valid,
   input  logic [WORD_W-1:0]   in_data,
   output logic                in_ready,
   input  logic [ADDR_W-1:0]   fetch_addr,
   output logic                fetch_stall,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output logic [4*WORD_W-1:0] mem_wdata,
   output logic                busy,
   output logic                done,
   output logic [31:0]         cksum,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LINE_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   len_q, len_d;
   logic [ADDR_W-1:0]   line_cnt_q, line_cnt_d;
   logic [1:0]          word_cnt_q, word_cnt_d;
   logic [4*WORD_W-1:0] pack_q, pack_d;

   // Next-state and datapath update: packing, line advance, termination.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      line_cnt_d = line_cnt_q;
      word_cnt_d = word_cnt_q;
      pack_d     = pack_q;
      case (state_q)
         ST_IDLE: begin
            // start is only honoured here; elsewhere it is ignored
            if (start) begin
               state_d    = ST_FILL;
               len_d      = load_len;
               line_cnt_d = '0;
               word_cnt_d = '0;
            end
         end
         ST_FILL: begin
            if (abort) begin
               // partial line is dropped, the word in flight is discarded
               state_d = ST_IDLE;
            end else if (in_valid) begin
               // first word of a line lands in the least significant slot
               case (word_cnt_q)
                  2'd0:    pack_d[0*WORD_W +: WORD_W] = in_data;
                  2'd1:    pack_d[1*WORD_W +: WORD_W] = in_data;
                  2'd2:    pack_d[2*WORD_W +: WORD_W] = in_data;
                  default: pack_d[3*WORD_W +: WORD_W] = in_data;
               endcase
               word_cnt_d = word_cnt_q + 2'd1;
               if (word_cnt_q == 2'd3) begin
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            // the write itself happens this cycle regardless of abort
            if (abort) begin
               state_d = ST_IDLE;
            end else if (line_cnt_q == len_q) begin
               state_d = ST_DONE;
            end else begin
               // the compare above ends the load before line_cnt can wrap
               line_cnt_d = line_cnt_q + LINE_ONE;
               word_cnt_d = '0;
               state_d    = ST_FILL;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any partial line.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         line_cnt_q <= '0;
         word_cnt_q <= '0;
         pack_q     <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         line_cnt_q <= line_cnt_d;
         word_cnt_q <= word_cnt_d;
         pack_q     <= pack_d;
      end
   end

`ifdef IMEM_LOADER_CKSUM_EN
   logic [31:0] cksum_q, cksum_d;

   // Running sum of accepted words; cleared by an honoured start, held otherwise.
   always_comb begin
      cksum_d = cksum_q;
      if (state_q == ST_IDLE && start) begin
         cksum_d = '0;
      end else if (state_q == ST_FILL && in_valid && !abort) begin
         cksum_d = cksum_q + 32'(in_data);
      end
   end

   // Checksum register.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         cksum_q <= '0;
      end else begin
         cksum_q <= cksum_d;
      end
   end

   assign cksum = cksum_q;
`else
   assign cksum = '0;
`endif

   // Outputs decode straight from the registered state so they cannot glitch
   // on input activity; only the address port is a combinational mux.
   assign in_ready    = (state_q == ST_FILL);
   assign mem_we      = (state_q == ST_WRITE);
   assign done        = (state_q == ST_DONE);
   assign busy        = (state_q != ST_IDLE);
   assign fetch_stall = busy;
   assign mem_addr    = busy ? line_cnt_q : fetch_addr;
   assign mem_wdata   = pack_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
// tb_imem_loader
// Directed sequence of loads with random words and gaps. Expected memory
// writes are rebuilt from the list of accepted words (four words per line,
// line i at address i); the checksum is the plain 32-bit sum of those words.
module tb_imem_loader;
   localparam int WORD_W = 32;
   localparam int ADDR_W = 9;
   localparam int LW     = 4 * WORD_W;
   localparam int SW     = ADDR_W + LW;
`ifdef IMEM_LOADER_CKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic              clk;
   logic              reset_x;
   logic              start;
   logic [ADDR_W-1:0] load_len;
   logic              abort;
   logic              in_valid;
   logic [WORD_W-1:0] in_data;
   logic              in_ready;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_stall;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [LW-1:0]     mem_wdata;
   logic              busy;
   logic              done;
   logic [31:0]       cksum;
   logic [1:0]        dbg_state;

   imem_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset_x(reset_x), .start(start), .load_len(load_len),
      .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .fetch_addr(fetch_addr), .fetch_stall(fetch_stall), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy), .done(done),
      .cksum(cksum), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [SW-1:0]     exp_q[$];
   logic [SW-1:0]     got_q[$];
   logic [WORD_W-1:0] words_q[$];
   logic [31:0]       exp_ck;
   int total = 0;
   int bad = 0;
   int got_base = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int start_cyc = 0;
   int stall_viol = 0;
   bit expect_busy = 1'b0;

   // Monitor: captures memory writes and done pulses mid-cycle.
   always @(negedge clk) begin
      if (mem_we) got_q.push_back({mem_addr, mem_wdata});
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (expect_busy && !fetch_stall) stall_viol++;
   end

   task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_cksum();
      return CK_EN ? exp_ck : 32'd0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [ADDR_W-1:0] len);
      start     = 1'b1;
      load_len  = len;
      start_cyc = cyc;
      step();
      start     = 1'b0;
      load_len  = ADDR_W'($urandom);
      words_q.delete();
      exp_ck      = '0;
      expect_busy = 1'b1;
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w, input int gap);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b0;
      repeat (gap) step();
      in_valid = 1'b1;
      in_data  = w;
      for (int t = 0; t < 16 && !ok; t++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("word_accept", ok, 1);
      if (ok) begin
         words_q.push_back(w);
         exp_ck += w;
      end
   endtask

   task automatic send_random(input int n, input int max_gap);
      for (int i = 0; i < n; i++) send_word($urandom, $urandom_range(0, max_gap));
   endtask

   task automatic wait_done(input int dc0, input int budget);
      int t;
      t = 0;
      while (done_cnt == dc0 && t < budget) begin
         @(negedge clk);
         #1;
         t++;
      end
      check("done_seen", done_cnt - dc0, 1);
      expect_busy = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic build_expected(input int nlines);
      for (int i = 0; i < nlines; i++) begin
         logic [LW-1:0] line;
         for (int k = 0; k < 4; k++) line[k*WORD_W +: WORD_W] = words_q[4*i+k];
         exp_q.push_back({ADDR_W'(i), line});
      end
   endtask

   task automatic compare_writes(input string tag);
      int n;
      n = got_q.size() - got_base;
      check({tag, "_nwrites"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < n; i++)
         check({tag, "_write"}, got_q[got_base+i], exp_q[i]);
      got_base = got_q.size();
      exp_q.delete();
   endtask

   task automatic reset_check(input string tag);
      @(negedge clk);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_fetch_stall"}, fetch_stall, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_mem_wdata"}, mem_wdata, 0);
      check({tag, "_cksum"}, cksum, 0);
      check({tag, "_mem_addr"}, mem_addr, fetch_addr);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int dc0;
      reset_x    = 1'b0;
      start      = 1'b0;
      load_len   = '0;
      abort      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      fetch_addr = ADDR_W'($urandom);
      exp_ck     = '0;

      // reset values
      repeat (2) @(posedge clk);
      reset_check("reset");
      @(posedge clk);
      #1;
      reset_x = 1'b1;
      step();

      // one line, fixed words, back-to-back
      dc0 = done_cnt;
      start_load(0);
      send_word(32'h11, 0);
      send_word(32'h22, 0);
      send_word(32'h33, 0);
      send_word(32'h44, 0);
      wait_done(dc0, 20);
      check("t1_done_lat", done_cyc - start_cyc, 6);
      if (got_q.size() > got_base)
         check("t1_wdata_const", got_q[got_base],
               {9'd0, 128'h00000044_00000033_00000022_00000011});
      check("t1_cksum", cksum, CK_EN ? 32'hAA : 32'h0);
      build_expected(1);
      compare_writes("t1");
      @(negedge clk);
      check("t1_idle_busy", busy, 0);
      check("t1_done_once", done_cnt - dc0, 1);
      step();

      // three lines with random gaps, fetch address restored afterwards
      fetch_addr = 9'h1F5;
      dc0 = done_cnt;
      start_load(2);
      send_random(12, 3);
      wait_done(dc0, 40);
      @(negedge clk);
      check("t2_busy", busy, 0);
      check("t2_mem_addr", mem_addr, 9'h1F5);
      check("t2_cksum", cksum, exp_cksum());
      build_expected(3);
      compare_writes("t2");
      step();

      // abort after six words, with a word offered in the abort cycle
      dc0 = done_cnt;
      start_load(3);
      send_random(6, 2);
      in_valid = 1'b1;
      in_data  = 32'hDEADBEEF;
      abort    = 1'b1;
      @(negedge clk);
      check("t3_abort_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      abort       = 1'b0;
      in_valid    = 1'b0;
      expect_busy = 1'b0;
      @(negedge clk);
      check("t3_idle_next", busy, 0);
      check("t3_cksum", cksum, exp_cksum());
      repeat (4) step();
      check("t3_no_done", done_cnt - dc0, 0);
      build_expected(1);
      compare_writes("t3");

      // abort in IDLE does nothing
      abort = 1'b1;
      step();
      abort = 1'b0;
      @(negedge clk);
      check("idle_abort_busy", busy, 0);
      check("idle_abort_cksum", cksum, exp_cksum());
      step();

      // stray start during FILL must not re-latch the length
      dc0 = done_cnt;
      start_load(1);
      send_random(2, 0);
      start    = 1'b1;
      load_len = 9'd5;
      send_word($urandom, 0);
      start = 1'b0;
      send_random(5, 0);
      wait_done(dc0, 40);
      check("t4_done_lat", done_cyc - start_cyc, 11);
      check("t4_cksum", cksum, exp_cksum());
      build_expected(2);
      compare_writes("t4");

      // reset asserted during the write of line 5
      start_load(7);
      send_random(24, 0);
      #2;
      reset_x     = 1'b0;
      expect_busy = 1'b0;
      reset_check("t5_reset");
      build_expected(5);
      compare_writes("t5");
      @(posedge clk);
      #1;
      reset_x = 1'b1;
      step();
      dc0 = done_cnt;
      start_load(0);
      send_random(4, 1);
      wait_done(dc0, 30);
      check("t5_cksum", cksum, exp_cksum());
      build_expected(1);
      compare_writes("t5_reload");

      // full memory, continuous input
      dc0 = done_cnt;
      start_load(9'd511);
      send_random(2048, 0);
      wait_done(dc0, 20);
      check("t6_done_lat", done_cyc - start_cyc, 2561);
      check("t6_cksum", cksum, exp_cksum());
      build_expected(512);
      compare_writes("t6");
      @(negedge clk);
      check("t6_busy", busy, 0);

      check("stall_during_load", stall_viol, 0);

      // ---------------- final report ----------------
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
